psum_accum: RTL

- Partial-sum accumulator directly downstream of the PE arithmetic unit array.
- Consumes one signed product per PE row per beat and accumulates a configurable number of beats per row.
- Presents the finished row sums to the output/writeback stage over a valid/ready handshake.
- Holds finished results until the consumer accepts them, so the arithmetic array can be stalled without losing data.

---
 rtl/psum_accum_if.sv | 26 ++
 rtl/psum_accum.sv | 83 ++++++++
 2 files changed

// File: rtl/psum_accum_if.sv
// psum_accum_if: product-in / row-sum-out handshake bundle for psum_accum
interface psum_accum_if #(
  parameter int DWD   = 8,
  parameter int PEROW = 4,
  parameter int ACCWD = 24,
  parameter int CNTWD = 8
);
  logic                        i_start;
  logic [CNTWD-1:0]            i_len;
  logic                        i_sum_valid;
  logic [PEROW-1:0][DWD-1:0]   i_sum;
  logic                        o_sum_ready;
  logic                        o_acc_valid;
  logic                        i_acc_ready;
  logic [PEROW-1:0][ACCWD-1:0] o_acc;
  logic [PEROW-1:0]            o_ovf;
  logic                        o_busy;
  modport master (
    output i_start, i_len, i_sum_valid, i_sum, i_acc_ready,
    input  o_sum_ready, o_acc_valid, o_acc, o_ovf, o_busy
  );
  modport slave (
    input  i_start, i_len, i_sum_valid, i_sum, i_acc_ready,
    output o_sum_ready, o_acc_valid, o_acc, o_ovf, o_busy
  );
endinterface

// File: rtl/psum_accum.sv
// psum_accum: per-row saturating partial-sum accumulator with held valid/ready result
module psum_accum #(
  parameter int DWD   = 8,
  parameter int PEROW = 4,
  parameter int ACCWD = 24,
  parameter int CNTWD = 8
) (
  input logic          i_clk,
  input logic          i_rst,
  psum_accum_if.slave  b
);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  state_t                      state;
  logic [CNTWD-1:0]            cnt;
  logic [CNTWD-1:0]            len_q;
  logic [CNTWD-1:0]            len_in;
  logic                        last;
  logic [PEROW-1:0][ACCWD:0]   wide;
  logic [PEROW-1:0][ACCWD-1:0] nxt;
  logic [PEROW-1:0]            sat;
  assign len_in = b.i_len == '0 ? CNTWD'(1) : b.i_len;
  assign last   = CNTWD'(cnt + 1'b1) == len_q;
  // one guard bit catches overflow; the first beat of a window loads instead of adding
  always_comb begin
    wide = '0;
    nxt  = '0;
    sat  = '0;
    for (int r = 0; r < PEROW; r++) begin
      wide[r] = (cnt == '0 ? '0 : {b.o_acc[r][ACCWD-1], b.o_acc[r]})
              + {{(ACCWD+1-DWD){b.i_sum[r][DWD-1]}}, b.i_sum[r]};
      sat[r]  = wide[r][ACCWD] ^ wide[r][ACCWD-1];
      nxt[r]  = !sat[r] ? wide[r][ACCWD-1:0]
              : wide[r][ACCWD] ? {1'b1, {(ACCWD-1){1'b0}}} : {1'b0, {(ACCWD-1){1'b1}}};
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      len_q         <= '0;
      b.o_acc       <= '0;
      b.o_ovf       <= '0;
      b.o_acc_valid <= 1'b0;
      b.o_sum_ready <= 1'b0;
      b.o_busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (b.i_start) begin
          len_q         <= len_in;
          cnt           <= '0;
          b.o_ovf       <= '0;
          state         <= ACC;
          b.o_sum_ready <= 1'b1;
          b.o_busy      <= 1'b1;
        end
        ACC: if (b.i_sum_valid) begin
          b.o_acc <= nxt;
          b.o_ovf <= b.o_ovf | sat;
          cnt     <= CNTWD'(cnt + 1'b1);
          if (last) begin
            state         <= HOLD;
            b.o_sum_ready <= 1'b0;
            b.o_acc_valid <= 1'b1;
          end
        end
        HOLD: if (b.i_acc_ready) begin
          b.o_acc_valid <= 1'b0;
          if (b.i_start) begin
            len_q         <= len_in;
            cnt           <= '0;
            b.o_ovf       <= '0;
            state         <= ACC;
            b.o_sum_ready <= 1'b1;
          end else begin
            state    <= IDLE;
            b.o_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
